dea_frame_tx: RTL and testbench

- UART transmit end of the DEA byte protocol.
- Buffers up to DEPTH result bytes written by the encryption datapath.
- On Start, serialises a length-prefixed frame on Tx: one length byte, then that many payload bytes, in the same 8N1 format and at the same bit rate as the existing receiver.
- Sits between the result buffer writer and the board Tx pin; replaces the unused sender path.

---
 rtl/dea_frame_tx_if.sv | 22 ++
 rtl/dea_frame_tx.sv | 164 ++++++++++++++++
 tb/tb_dea_frame_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dea_frame_tx_if.sv
// Bus between the result-buffer writer / frame requester and the DEA frame transmitter.
// The master side writes the payload buffer and requests frames; the slave is the transmitter.
interface dea_frame_tx_if;
  logic       Wr_En;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Start;
  logic [7:0] Length;
  logic       Busy;
  logic       Done;
  logic       Tx;

  modport master (
    output Wr_En, Wr_Addr, Wr_Data, Start, Length,
    input  Busy, Done, Tx
  );

  modport slave (
    input  Wr_En, Wr_Addr, Wr_Data, Start, Length,
    output Busy, Done, Tx
  );
endinterface

// File: rtl/dea_frame_tx.sv
// UART transmit end of the DEA byte protocol: buffers result bytes and, on Start,
// sends a length-prefixed 8N1 frame (length byte, then payload bytes) on Tx.
module dea_frame_tx #(
  parameter int             N     = 14,
  parameter logic [N-1:0]   M     = 14'd9999,
  parameter int             DEPTH = 100
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  dea_frame_tx_if.slave     bus,
  output logic [1:0]        dbg_state_o
);

  // Handshake: Start/Length are sampled on any rising edge where the FSM is IDLE;
  // Busy is high for the whole frame and Done pulses for one cycle on completion
  // (or immediately for a zero-length request). Start while Busy is dropped.

  localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]   DEPTH_B = 8'(DEPTH);
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START_BIT = 2'd1,
    S_DATA_BITS = 2'd2,
    S_STOP_BIT  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   idx_q, idx_d;
  logic [7:0]   len_q, len_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [7:0]   buf_q [DEPTH];

  logic [7:0]   len_c;
  logic         bit_end;
  logic         wr_ok;

  assign len_c   = (bus.Length > DEPTH_B) ? DEPTH_B : bus.Length;
  assign bit_end = (cnt_q == M);
  // Busy freezes the buffer so the frame content cannot change underneath the sender.
  assign wr_ok   = bus.Wr_En && !busy_q && (bus.Wr_Addr < DEPTH_B);

  always_ff @(posedge Clk_100M) begin
    if (wr_ok) begin
      buf_q[bus.Wr_Addr[AW-1:0]] <= bus.Wr_Data;
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.Start) begin
          if (len_c == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_START_BIT;
            shift_d = len_c;
            len_d   = len_c;
            idx_d   = 8'd0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      S_START_BIT: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        if (bit_end) begin
          state_d = S_DATA_BITS;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA_BITS: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end

      S_STOP_BIT: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        if (bit_end) begin
          // Next payload byte follows the stop bit directly, with no idle gap.
          if (idx_q < len_q) begin
            state_d = S_START_BIT;
            shift_d = buf_q[idx_q[AW-1:0]];
            idx_d   = idx_q + 8'd1;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.Tx      = tx_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dea_frame_tx.sv
// Bench for dea_frame_tx with 4 clocks per bit: a UART monitor decodes Tx and
// compares every received byte against a queue filled when frames are requested.
module tb_dea_frame_tx;
  localparam int DEPTH = 100;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  dea_frame_tx_if bus();

  dea_frame_tx #(.N(14), .M(14'd3), .DEPTH(DEPTH)) dut (
    .Clk_100M    (clk),
    .Reset       (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_now  = 0;
  int rx_count = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] exp_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = addr;
    bus.Wr_Data = data;
    tick();
    bus.Wr_En   = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] len);
    int l;
    l = (len > DEPTH) ? DEPTH : int'(len);
    if (l != 0) begin
      exp_q.push_back(8'(l));
      for (int i = 0; i < l; i++) exp_q.push_back(mem[i]);
    end
  endtask

  task automatic start_frame(input logic [7:0] len);
    push_frame(len);
    bus.Start  = 1'b1;
    bus.Length = len;
    tick();
    bus.Start  = 1'b0;
  endtask

  task automatic wait_done(output int busy_lo);
    int budget;
    busy_lo = 0;
    budget  = 0;
    while (bus.Done !== 1'b1 && budget < 6000) begin
      if (bus.Busy !== 1'b1) busy_lo++;
      tick();
      budget++;
    end
    check("done_seen", bus.Done, 1'b1);
  endtask

  // UART monitor / scoreboard: sample mid-bit, 4 clocks per bit
  initial begin
    logic [7:0] got;
    logic       abort;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || bus.Tx !== 1'b0) continue;
      abort = 1'b0;
      got   = '0;
      for (int off = 1; off <= 38; off++) begin
        @(negedge clk);
        if (rst !== 1'b0) begin
          abort = 1'b1;
          break;
        end
        if (off == 2) check("start_bit", bus.Tx, 1'b0);
        if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) got[(off - 6) / 4] = bus.Tx;
        if (off == 38) check("stop_bit", bus.Tx, 1'b1);
      end
      if (!abort) begin
        rx_count++;
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, got}, 32'hFFFF_FFFF);
        else check("rx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int t0;
    int lo;
    int cnt_a;
    int cnt_b;
    int rx0;
    logic [7:0] d;

    rst         = 1'b1;
    bus.Wr_En   = 1'b0;
    bus.Wr_Addr = '0;
    bus.Wr_Data = '0;
    bus.Start   = 1'b0;
    bus.Length  = '0;
    repeat (3) tick();
    check("rst_tx", bus.Tx, 1'b1);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      d = (i < 3) ? 8'(8'h41 + i) : 8'($urandom_range(0, 255));
      mem[i] = d;
      wr(8'(i), d);
    end
    wr(8'd100, 8'hEE);
    for (int i = 0; i < 8; i++) wr(8'($urandom_range(101, 255)), 8'($urandom_range(0, 255)));

    // basic 3-byte frame
    start_frame(8'd3);
    t0 = cyc_now;
    check("f3_busy_rise", bus.Busy, 1'b1);
    check("f3_tx_start", bus.Tx, 1'b0);
    wait_done(lo);
    check("f3_done_cycle", cyc_now - t0 + 1, 161);
    check("f3_busy_gaps", lo, 0);
    check("f3_busy_at_done", bus.Busy, 1'b0);
    tick();
    check("f3_done_pulse", bus.Done, 1'b0);
    check("f3_q_empty", exp_q.size(), 0);

    // writes and Start while busy are dropped
    start_frame(8'd3);
    t0 = cyc_now;
    repeat (30) tick();
    wr(8'd0, 8'hFF);
    bus.Start  = 1'b1;
    bus.Length = 8'd5;
    tick();
    bus.Start  = 1'b0;
    wait_done(lo);
    check("busyw_done_cycle", cyc_now - t0 + 1, 161);
    cnt_a = 0;
    repeat (60) begin
      tick();
      if (bus.Busy !== 1'b0) cnt_a++;
    end
    check("busyw_no_second", cnt_a, 0);
    check("busyw_q_empty", exp_q.size(), 0);

    // reset mid-frame
    start_frame(8'd3);
    t0 = cyc_now;
    while (cyc_now - t0 + 1 < 50) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", bus.Tx, 1'b1);
    check("midrst_busy", bus.Busy, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    cnt_a = 0;
    cnt_b = 0;
    repeat (120) begin
      if (bus.Done !== 1'b0) cnt_a++;
      if (bus.Tx !== 1'b1) cnt_b++;
      tick();
    end
    check("midrst_no_done", cnt_a, 0);
    check("midrst_tx_idle", cnt_b, 0);
    start_frame(8'd1);
    t0 = cyc_now;
    wait_done(lo);
    check("after_rst_done_cycle", cyc_now - t0 + 1, 81);
    check("after_rst_q_empty", exp_q.size(), 0);

    // zero-length request
    tick();
    start_frame(8'd0);
    check("len0_done", bus.Done, 1'b1);
    check("len0_busy", bus.Busy, 1'b0);
    check("len0_tx", bus.Tx, 1'b1);
    tick();
    check("len0_done_pulse", bus.Done, 1'b0);
    check("len0_tx_after", bus.Tx, 1'b1);
    check("len0_state", dbg_state, 2'd0);

    // over-long request is clamped to DEPTH
    rx0 = rx_count;
    start_frame(8'd150);
    t0 = cyc_now;
    wait_done(lo);
    check("clamp_done_cycle", cyc_now - t0 + 1, 4041);
    check("clamp_busy_gaps", lo, 0);
    check("clamp_bytes", rx_count - rx0, 101);
    check("clamp_q_empty", exp_q.size(), 0);

    // back-to-back frames: Start held until the Done cycle
    tick();
    start_frame(8'd1);
    repeat (10) tick();
    bus.Start  = 1'b1;
    bus.Length = 8'd1;
    wait_done(lo);
    push_frame(8'd1);
    tick();
    bus.Start = 1'b0;
    t0 = cyc_now;
    check("b2b_tx_no_gap", bus.Tx, 1'b0);
    check("b2b_busy", bus.Busy, 1'b1);
    wait_done(lo);
    check("b2b_done_cycle", cyc_now - t0 + 1, 81);
    tick();
    check("b2b_q_empty", exp_q.size(), 0);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
